// File: rtl/fb_arbiter.sv
// Purpose : shares one single-port framebuffer SRAM between the display reader and the pixel writer.
// Latency : SRAM controls registered on the transfer edge; read data returns two edges after the read transfer.
// Backpressure: grants are combinational; reads win, but a writer eligible for MAX_WAIT edges is force-granted once.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   rdReq/rdAddr/rdGnt            display read request, address, combinational grant
//   rdValid/rdData                one-cycle read-data strobe and data
//   wrReq/wrAddr/wrData/wrGnt     writer request, address, data, combinational grant
//   vblank                        vertical blanking flag (gates writes when WR_VBLANK_ONLY=1)
//   memAddr/memWe/memWdata        registered SRAM controls
//   memRdata                      SRAM read data, valid one cycle after the address is presented
module fb_arbiter #(
    parameter int ADDR_W         = 19,
    parameter int DATA_W         = 16,
    parameter int MAX_WAIT       = 8,
    parameter int WR_VBLANK_ONLY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdGnt,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrGnt,
    input  logic              vblank,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       wr_elig;
    logic       rd_xfer;
    logic       wr_xfer;
    logic       rd_tag1;   // read address presented to SRAM this cycle
    logic       rd_tag2;   // SRAM read data arrives on memRdata this cycle

    assign wr_elig = wrReq & ((WR_VBLANK_ONLY == 0) | vblank);

    // Grants, transfers, wait counter and next state.
    always_comb begin
        rdGnt        = 1'b0;
        wrGnt        = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;

        if (!reset) begin
            case (state)
                ST_NORMAL: begin
                    rdGnt = rdReq;
                    wrGnt = wr_elig & ~rdReq;
                end
                ST_FORCE: begin
                    wrGnt = wr_elig;
                end
                default: begin
                    rdGnt = 1'b0;
                    wrGnt = 1'b0;
                end
            endcase
        end

        rd_xfer = rdReq & rdGnt;
        wr_xfer = wrReq & wrGnt;

        // Counter measures how long an eligible writer has gone unserved.
        if (wr_xfer || !wr_elig) begin
            wait_cnt_nxt = 8'd0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end

        case (state)
            ST_NORMAL: begin
                if (wait_cnt_nxt >= MAX_WAIT_C) begin
                    state_nxt = ST_FORCE;
                end
            end
            ST_FORCE: begin
                // Forced slot lasts one cycle: either the write goes or the writer lost eligibility.
                if (wr_xfer || !wr_elig) begin
                    state_nxt = ST_NORMAL;
                end
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_NORMAL;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // SRAM control registers and read-return pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            memAddr  <= '0;
            memWe    <= 1'b0;
            memWdata <= '0;
            rd_tag1  <= 1'b0;
            rd_tag2  <= 1'b0;
            rdValid  <= 1'b0;
            rdData   <= '0;
        end else begin
            memWe   <= wr_xfer;
            rd_tag1 <= rd_xfer;
            rd_tag2 <= rd_tag1;
            rdValid <= rd_tag2;
            if (rd_xfer) begin
                memAddr <= rdAddr;
            end else if (wr_xfer) begin
                memAddr  <= wrAddr;
                memWdata <= wrData;
            end
            if (rd_tag2) begin
                rdData <= memRdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 8;
    localparam int MEM_N    = 1024;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus; dut0 writes any time, dut1 only during vblank.
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              vblank;

    logic [1:0]        rd_gnt;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_valid;
    logic [1:0]        mem_we;
    logic [DATA_W-1:0] rd_data   [2];
    logic [ADDR_W-1:0] mem_addr  [2];
    logic [DATA_W-1:0] mem_wdata [2];
    logic [DATA_W-1:0] mem_rdata [2];

    int n_checks = 0;
    int n_fail   = 0;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WR_VBLANK_ONLY(0)) dut0 (
        .clock(clk), .reset(reset),
        .rdReq(rd_req), .rdAddr(rd_addr), .rdGnt(rd_gnt[0]),
        .rdValid(rd_valid[0]), .rdData(rd_data[0]),
        .wrReq(wr_req), .wrAddr(wr_addr), .wrData(wr_data), .wrGnt(wr_gnt[0]),
        .vblank(vblank),
        .memAddr(mem_addr[0]), .memWe(mem_we[0]), .memWdata(mem_wdata[0]),
        .memRdata(mem_rdata[0])
    );

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WR_VBLANK_ONLY(1)) dut1 (
        .clock(clk), .reset(reset),
        .rdReq(rd_req), .rdAddr(rd_addr), .rdGnt(rd_gnt[1]),
        .rdValid(rd_valid[1]), .rdData(rd_data[1]),
        .wrReq(wr_req), .wrAddr(wr_addr), .wrData(wr_data), .wrGnt(wr_gnt[1]),
        .vblank(vblank),
        .memAddr(mem_addr[1]), .memWe(mem_we[1]), .memWdata(mem_wdata[1]),
        .memRdata(mem_rdata[1])
    );

    // SRAM behaviour: one-cycle synchronous read, write on the edge memWe is seen.
    logic [DATA_W-1:0] sram  [2][MEM_N];
    logic [DATA_W-1:0] m_mem [2][MEM_N];

    initial begin
        for (int i = 0; i < MEM_N; i++) begin
            sram[0][i]  = i[DATA_W-1:0];
            sram[1][i]  = i[DATA_W-1:0];
            m_mem[0][i] = i[DATA_W-1:0];
            m_mem[1][i] = i[DATA_W-1:0];
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mem_rdata[d] <= sram[d][mem_addr[d][9:0]];
            if (mem_we[d] === 1'b1) sram[d][mem_addr[d][9:0]] = mem_wdata[d];
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Reference model: grants from "how long has the writer waited", outputs
    // from an in-order list of transfers and a memory image.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } pend_t;

    pend_t             q0[$];
    pend_t             q1[$];
    int                m_wait  [2];
    logic [ADDR_W-1:0] e_addr  [2];
    logic              e_we    [2];
    logic [DATA_W-1:0] e_wdata [2];
    logic              e_valid [2];
    logic [DATA_W-1:0] e_rdata [2];
    bit                m_known = 1'b0;
    int                cyc     = 0;

    logic c_elig, c_frc, c_wr, c_rd;
    pend_t c_p;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            c_elig = wr_req & ((d == 0) | vblank);
            c_frc  = (m_wait[d] >= MAX_WAIT);
            c_wr   = !reset & c_elig & (c_frc | !rd_req);
            c_rd   = !reset & rd_req & !c_frc;
            chk("wrGnt", d, 32'(wr_gnt[d]), 32'(c_wr));
            chk("rdGnt", d, 32'(rd_gnt[d]), 32'(c_rd));
            if (m_known) begin
                chk("memAddr",  d, 32'(mem_addr[d]),  32'(e_addr[d]));
                chk("memWe",    d, 32'(mem_we[d]),    32'(e_we[d]));
                chk("memWdata", d, 32'(mem_wdata[d]), 32'(e_wdata[d]));
                chk("rdValid",  d, 32'(rd_valid[d]),  32'(e_valid[d]));
                chk("rdData",   d, 32'(rd_data[d]),   32'(e_rdata[d]));
            end
            // Advance the model across the coming rising edge.
            if (reset) begin
                m_wait[d]  = 0;
                e_addr[d]  = '0;
                e_we[d]    = 1'b0;
                e_wdata[d] = '0;
                e_valid[d] = 1'b0;
                e_rdata[d] = '0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                e_valid[d] = 1'b0;
                if (d == 0 && q0.size() > 0 && q0[0].due == cyc + 1) begin
                    c_p = q0.pop_front();
                    e_valid[d] = 1'b1;
                    e_rdata[d] = c_p.data;
                end
                if (d == 1 && q1.size() > 0 && q1[0].due == cyc + 1) begin
                    c_p = q1.pop_front();
                    e_valid[d] = 1'b1;
                    e_rdata[d] = c_p.data;
                end
                if (c_rd) begin
                    c_p.due  = cyc + 3;
                    c_p.data = m_mem[d][rd_addr[9:0]];
                    if (d == 0) q0.push_back(c_p); else q1.push_back(c_p);
                    e_addr[d] = rd_addr;
                    e_we[d]   = 1'b0;
                end else if (c_wr) begin
                    m_mem[d][wr_addr[9:0]] = wr_data;
                    e_addr[d]  = wr_addr;
                    e_wdata[d] = wr_data;
                    e_we[d]    = 1'b1;
                end else begin
                    e_we[d] = 1'b0;
                end
                if (c_wr || !c_elig) m_wait[d] = 0;
                else                 m_wait[d] = m_wait[d] + 1;
            end
        end
        if (reset) m_known = 1'b1;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        m_wait[0] = 0;
        m_wait[1] = 0;
        reset   = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        vblank  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_memAddr", 0, 32'(mem_addr[0]), 32'h0);
        chk("rst_rdValid", 1, 32'(rd_valid[1]), 32'h0);
        step();

        // Three back-to-back reads, memory holds data = address.
        rd_req = 1'b1; rd_addr = 19'h10;
        #1 chk("t1_gnt", 0, 32'(rd_gnt[0]), 32'h1);
        step(); rd_addr = 19'h11;
        step(); rd_addr = 19'h12;
        chk("t1_early", 0, 32'(rd_valid[0]), 32'h0);
        step(); idle();
        chk("t1_v0", 0, 32'(rd_valid[0]), 32'h1);
        chk("t1_d0", 0, 32'(rd_data[0]), 32'h10);
        chk("t1_we", 0, 32'(mem_we[0]), 32'h0);
        step();
        chk("t1_v1", 0, 32'(rd_valid[0]), 32'h1);
        chk("t1_d1", 0, 32'(rd_data[0]), 32'h11);
        step();
        chk("t1_d2", 1, 32'(rd_data[1]), 32'h12);
        step();
        chk("t1_end", 0, 32'(rd_valid[0]), 32'h0);

        // Single write, no reads.
        wr_req = 1'b1; wr_addr = 19'h100; wr_data = 16'hBEEF; vblank = 1'b1;
        #1 chk("t2_gnt0", 0, 32'(wr_gnt[0]), 32'h1);
        chk("t2_gnt1", 1, 32'(wr_gnt[1]), 32'h1);
        step(); idle();
        chk("t2_we", 0, 32'(mem_we[0]), 32'h1);
        chk("t2_addr", 0, 32'(mem_addr[0]), 32'h100);
        chk("t2_data", 0, 32'(mem_wdata[0]), 32'hBEEF);
        step();
        chk("t2_we_off", 0, 32'(mem_we[0]), 32'h0);

        // Continuous reads and writes: forced write at edges 9 and 18.
        rd_req = 1'b1; rd_addr = 19'h30;
        wr_req = 1'b1; wr_addr = 19'h31; wr_data = 16'h1234;
        for (int e = 1; e <= 18; e++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("t3_wr", d, 32'(wr_gnt[d]), 32'((e == 9) || (e == 18)));
                chk("t3_rd", d, 32'(rd_gnt[d]), 32'(!((e == 9) || (e == 18))));
            end
            step();
        end
        idle(); step(); step();

        // Vblank gating on dut1: no grant and no waiting while vblank is low.
        vblank = 1'b0; wr_req = 1'b1; wr_addr = 19'h40; wr_data = 16'h5A5A;
        for (int i = 0; i < 20; i++) begin
            #1 chk("t4_gated", 1, 32'(wr_gnt[1]), 32'h0);
            step();
        end
        vblank = 1'b1; rd_req = 1'b1; rd_addr = 19'h41;
        #1 chk("t4_rd_wins", 1, 32'(rd_gnt[1]), 32'h1);
        chk("t4_no_force", 1, 32'(wr_gnt[1]), 32'h0);
        step(); rd_req = 1'b0;
        #1 chk("t4_wr", 1, 32'(wr_gnt[1]), 32'h1);
        step(); idle(); step();

        // Vblank falls while forced: dut1 drops to normal next edge.
        rd_req = 1'b1; wr_req = 1'b1; vblank = 1'b1;
        repeat (8) step();
        vblank = 1'b0;
        #1 chk("t5_rd_blk", 1, 32'(rd_gnt[1]), 32'h0);
        chk("t5_wr_blk", 1, 32'(wr_gnt[1]), 32'h0);
        chk("t5_wr_dut0", 0, 32'(wr_gnt[0]), 32'h1);
        step();
        #1 chk("t5_rd_back", 1, 32'(rd_gnt[1]), 32'h1);
        chk("t5_no_we", 1, 32'(mem_we[1]), 32'h0);
        idle(); step();

        // Forced, then writer withdraws before the transfer.
        rd_req = 1'b1; wr_req = 1'b1; vblank = 1'b1;
        repeat (8) step();
        wr_req = 1'b0;
        #1 chk("t6_rd_blk", 0, 32'(rd_gnt[0]), 32'h0);
        chk("t6_wr_off", 0, 32'(wr_gnt[0]), 32'h0);
        step();
        #1 chk("t6_rd_back", 0, 32'(rd_gnt[0]), 32'h1);
        chk("t6_no_we", 0, 32'(mem_we[0]), 32'h0);
        idle(); step();

        // Read accepted, then reset on the next edge: data never returns.
        rd_req = 1'b1; rd_addr = 19'h20;
        step(); rd_req = 1'b0; reset = 1'b1;
        step(); reset = 1'b0;
        chk("t7_addr", 0, 32'(mem_addr[0]), 32'h0);
        chk("t7_we", 0, 32'(mem_we[0]), 32'h0);
        chk("t7_wdata", 0, 32'(mem_wdata[0]), 32'h0);
        chk("t7_rdata", 0, 32'(rd_data[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t7_valid", 0, 32'(rd_valid[0]), 32'h0);
            step();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(199) == 0);
            rd_req  = ($urandom_range(99) < 60);
            wr_req  = ($urandom_range(99) < 55);
            rd_addr = 19'($urandom_range(31));
            wr_addr = 19'($urandom_range(31));
            wr_data = 16'($urandom);
            if ($urandom_range(99) < 8) vblank = ~vblank;
            step();
        end
        reset = 1'b0;
        idle();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares one synchronous single-port framebuffer SRAM between two requesters: the display scan-out reader, fed by the pixel timing generator's row/column counters, and the air-hockey game-logic pixel writer. Reads have fixed priority. A starvation guard bounds writer latency, and an optional vertical-blank gate restricts writes to blanking to prevent tearing. The block registers all SRAM control signals and returns read data with fixed latency.

## Interface
- ADDR_W, 19, framebuffer word address width
- DATA_W, 16, pixel word width
- MAX_WAIT, 8, writer wait cycles before forced grant (legal range 1..255)
- WR_VBLANK_ONLY, 0, 1 = writes eligible only while vblank=1

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rdReq  in  1  display read request
- rdAddr  in  ADDR_W  read address, stable while rdReq=1 and not granted
- rdGnt  out  1  combinational read grant; transfer = rdReq & rdGnt at posedge
- rdValid  out  1  read data valid strobe
- rdData  out  DATA_W  read data
- wrReq  in  1  writer request
- wrAddr  in  ADDR_W  write address
- wrData  in  DATA_W  write data
- wrGnt  out  1  combinational write grant; transfer = wrReq & wrGnt at posedge
- vblank  in  1  high during vertical blanking (from timing generator)
- memAddr  out  ADDR_W  registered SRAM address
- memWe  out  1  registered SRAM write enable
- memWdata  out  DATA_W  registered SRAM write data
- memRdata  in  DATA_W  SRAM read data, valid 1 cycle after address presented

## Operation
- Write eligibility: wrElig = wrReq & (WR_VBLANK_ONLY==0 | vblank).
- FSM states: NORMAL, FORCE.
  - NORMAL: rdGnt = rdReq; wrGnt = wrElig & ~rdReq.
  - FORCE: wrGnt = wrElig; rdGnt = 0.
  - NORMAL -> FORCE when waitCnt reaches MAX_WAIT.
  - FORCE -> NORMAL on a write transfer, or when wrElig=0 (request withdrawn or vblank dropped).
- waitCnt (8 bit, saturating):
  - increments each posedge with wrElig=1 and no write transfer.
  - clears on a write transfer or when wrElig=0.
- Grants are mutually exclusive in every cycle. Both grants are forced 0 while reset=1.
- On a read transfer at posedge N:
  - memAddr<=rdAddr and memWe<=0 at N.
  - read-pending tag set at N; at N+1 the tag moves to stage 2 while SRAM samples the address.
  - rdData<=memRdata and rdValid<=1 at N+2.
- On a write transfer: memAddr<=wrAddr, memWdata<=wrData, memWe<=1 at the same posedge.
- No transfer in a cycle: memWe<=0; memAddr and memWdata hold.
- rdValid is a 1-cycle strobe per read. Back-to-back reads give back-to-back rdValid with addresses in order.
- Reset mid-operation clears the read-pending pipeline. rdValid is never asserted for a read accepted before reset.

## Timing
- Reset values: memAddr=0, memWe=0, memWdata=0, rdValid=0, rdData=0, state=NORMAL, waitCnt=0, pipeline tags=0.
- Read latency: rdValid high in the cycle after posedge N+2 for a transfer at posedge N.
- Throughput: one access per cycle (read or write).
- Worst-case write latency with continuous reads and writes eligible: MAX_WAIT+1 cycles from wrReq rising to write transfer.
- The display loses exactly one slot per forced write. Upstream absorbs this with its prefetch FIFO.
- vblank falling while in FORCE: return to NORMAL next edge (WR_VBLANK_ONLY=1). waitCnt clears.
- Simultaneous rdReq and wrReq in NORMAL with waitCnt<MAX_WAIT: read wins.
- Requesters may change address or data in the cycle after a transfer. Holding req with a new address issues a new access.

## Test plan
- Reset, then 3 consecutive reads at addresses 0x10, 0x11, 0x12 with memory modelled (data = address) -> rdValid high 3 consecutive cycles starting 2 cycles after first grant, rdData 0x10, 0x11, 0x12; memWe stays 0.
- Single write addr 0x100 data 0xBEEF, no reads -> wrGnt=1 immediately; next cycle memWe=1, memAddr=0x100, memWdata=0xBEEF; following cycle memWe=0.
- Continuous rdReq plus wrReq from cycle 0, MAX_WAIT=8 -> exactly one write transfer at the 9th edge; rdGnt=0 only in that cycle; state back to NORMAL; waitCnt restarts and next forced write 9 cycles later.
- WR_VBLANK_ONLY=1, wrReq held, vblank=0 for 20 cycles then 1 -> wrGnt=0 and waitCnt=0 throughout vblank=0; wrGnt=1 the first cycle vblank=1 with no read.
- Read transfer, then reset asserted the next cycle for 1 cycle -> rdValid never asserted; all outputs at reset values the cycle after reset.
- FORCE reached, then wrReq dropped before transfer -> state NORMAL next edge, rdGnt follows rdReq again, no memWe pulse.
